// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch queue between imem and the control-unit LUT
// Optional feature macro: IFQ_ILLEGAL_CHECK_EN (flag heads that are not 32-bit encodings)
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic        En,
    output logic        illegal
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];

    logic [CW:0]   w_credit_used;
    logic [31:0]   w_redirect_pc;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_inflight_after;

    assign w_redirect_pc    = redirect_pc & 32'hFFFF_FFFC;
    assign w_credit_used    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req         = rst_n && !redirect && (w_credit_used < CREDITS);
    assign imem_addr        = r_fetch_pc;
    assign w_grant          = imem_req && imem_gnt;
    assign w_push           = imem_rvalid && (r_drop == '0);
    assign w_pop            = dec_valid && !stall;
    assign w_inflight_after = r_outstanding - CW'(imem_rvalid);

    // Non-dropped responses are always the sequential continuation of the
    // last redirect target, so a running PC replaces a per-request tag FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= w_inflight_after;
            r_drop        <= w_inflight_after;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
            if (imem_rvalid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !redirect && w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign dec_valid = (r_count != '0);
    assign dec_pc    = dec_valid ? r_pc_mem[r_rd_ptr] : 32'd0;
    assign dec_instr = dec_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
    assign opcode    = dec_instr[6:0];
    assign func3     = dec_instr[14:12];
    assign func7     = dec_instr[31:25];

`ifdef IFQ_ILLEGAL_CHECK_EN
    assign illegal = dec_valid && (dec_instr[1:0] != 2'b11);
`else
    assign illegal = 1'b0;
`endif
    assign En = dec_valid && !illegal;

    // Credits bound count + outstanding, so a full queue never sees a push.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(w_push && !redirect && (r_count == FULL)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        En;
    logic        illegal;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .opcode(opcode), .func3(func3), .func7(func7),
        .En(En), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       mq[$];
    int          cyc;
    int          lat;
    int          checks;
    int          errors;
    logic        use_fixed;
    logic [31:0] fixed_word;

`ifdef IFQ_ILLEGAL_CHECK_EN
    localparam logic ILL_EXP = 1'b1;
    localparam logic EN_EXP  = 1'b0;
`else
    localparam logic ILL_EXP = 1'b0;
    localparam logic EN_EXP  = 1'b1;
`endif

    function automatic logic [31:0] memf(input logic [31:0] a);
        return use_fixed ? fixed_word : {a[21:2], 12'h013};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge; models an in-order memory with latency lat.
    task automatic cycle();
        logic        granted;
        logic [31:0] gaddr;
        imem_rvalid = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rdata  = imem_rvalid ? memf(mq[0].addr) : 32'd0;
        #1;
        granted = imem_req && imem_gnt;
        gaddr   = imem_addr;
        @(posedge clk);
        if (imem_rvalid) void'(mq.pop_front());
        if (granted) mq.push_back('{gaddr, cyc + lat});
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        lat         = 1;
        use_fixed   = 1'b0;
        fixed_word  = 32'd0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        stall       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        @(negedge clk);
        cycle();
        cycle();

        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", dec_valid, 0);
        chk("rst_en", En, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", dec_pc, 0);
        chk("rst_instr", dec_instr, 0);
        chk("rst_fields", {opcode, func3, func7}, 0);

        // sequential fetch, 1-cycle memory
        rst_n = 1'b1;
        #1;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        cycle();
        chk("addr1", imem_addr, 32'h4);
        chk("valid_not_yet", dec_valid, 0);
        cycle();
        chk("valid_lat", dec_valid, 1);
        chk("head_pc0", dec_pc, 32'h0);
        chk("head_instr0", dec_instr, 32'h0000_0013);
        chk("opcode0", opcode, 7'h13);
        chk("en0", En, 1);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("seq_pc", dec_pc, 32'(4 * k));
            chk("seq_opcode", opcode, 7'h13);
        end

        // stall fills exactly DEPTH entries, then drains in order
        stall = 1'b1;
        repeat (10) cycle();
        chk("stall_head", dec_pc, 32'd16);
        chk("stall_req_low", imem_req, 0);
        chk("stall_next_addr", imem_addr, 32'd32);
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("drain_valid", dec_valid, 1);
            chk("drain_pc", dec_pc, 32'(16 + 4 * k));
        end

        // redirect with several requests in flight
        lat = 3;
        repeat (3) cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req_low", imem_req, 0);
        cycle();
        redirect = 1'b0;
        #1;
        chk("redir_flush", dec_valid, 0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_req", imem_req, 1);
        for (int i = 0; i < 20 && !dec_valid; i++) cycle();
        chk("redir_valid", dec_valid, 1);
        chk("redir_first_pc", dec_pc, 32'h100);
        chk("redir_first_instr", dec_instr, memf(32'h100));

        // redirect colliding with a response and a pop
        lat = 1;
        repeat (8) cycle();
        chk("pre_redir_valid", dec_valid, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        #1;
        chk("coll_empty", dec_valid, 0);
        chk("coll_en", En, 0);
        chk("coll_addr", imem_addr, 32'h200);
        cycle();
        chk("coll_lat1", dec_valid, 0);
        cycle();
        chk("coll_valid", dec_valid, 1);
        chk("coll_pc", dec_pc, 32'h200);

        // fetch PC wraps at 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr1", imem_addr, 32'h0);
        cycle();
        chk("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc1", dec_pc, 32'h0);

        // compressed-looking encoding at the head
        use_fixed   = 1'b1;
        fixed_word  = 32'h0000_0001;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect = 1'b0;
        cycle();
        cycle();
        chk("ill_valid", dec_valid, 1);
        chk("ill_pc", dec_pc, 32'h300);
        chk("ill_opcode", opcode, 7'h01);
        chk("ill_flag", illegal, ILL_EXP);
        chk("ill_en", En, EN_EXP);
        stall = 1'b1;
        cycle();
        chk("ill_held", dec_pc, 32'h300);
        stall = 1'b0;
        cycle();
        chk("ill_popped", dec_pc, 32'h304);

        // reset in mid-operation
        use_fixed = 1'b0;
        rst_n     = 1'b0;
        mq.delete();
        cycle();
        chk("mid_rst_valid", dec_valid, 0);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_en", En, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", imem_req, 1);
        cycle();
        cycle();
        chk("post_rst_valid", dec_valid, 1);
        chk("post_rst_pc", dec_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
